// File: rtl/wb_arb_stage.sv
// Writeback stage: load-data extension plus arbitration of the single register-file
// write port between the in-order pipeline and a queued long-latency result stream.
module wb_arb_stage #(
  parameter int XLEN       = 32,
  parameter int RW         = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_regWrite,
  input  logic                   in_memToReg,
  input  logic                   in_isLOADS,
  input  logic [1:0]             in_size,
  input  logic [RW-1:0]          in_rw,
  input  logic [XLEN-1:0]        in_EXout,
  input  logic [XLEN-1:0]        in_Dout,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [RW-1:0]          lu_rd,
  input  logic [XLEN-1:0]        lu_data,
  output logic                   o_WB_regWrite,
  output logic [XLEN+RW:0]       o_WB_BACK,
  output logic [$clog2(DEPTH):0] o_lu_count
);

  localparam int L  = $clog2(XLEN / 8);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Lane select by aligned offset, then keep the field and fill the rest with sign or zero.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                               input logic [L-1:0]    off,
                                               input logic [1:0]      sz,
                                               input logic            sgn);
    logic [L-1:0]    o;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            top;
    o = off;
    case (sz)
      2'b00:   o = off;
      2'b01:   o[0] = 1'b0;
      2'b10:   o[1:0] = 2'b00;
      default: o = '0;
    endcase
    sh = d >> {o, 3'b000};
    case (sz)
      2'b00:   begin keep = XLEN'(8'hFF);         top = sh[7];      end
      2'b01:   begin keep = XLEN'(16'hFFFF);      top = sh[15];     end
      2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); top = sh[31];     end
      default: begin keep = '1;                   top = sh[XLEN-1]; end
    endcase
    return (sh & keep) | ((sgn && top) ? ~keep : '0);
  endfunction

  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [RW-1:0]   mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_wd_q, wb_wd_d;
  logic [RW-1:0]   wb_rw_q, wb_rw_d;

  logic            nonempty, force_head, pipe_req, pipe_grant, head_grant, push;
  logic [XLEN-1:0] wd_pipe;

  assign nonempty   = (count_q != '0);
  assign force_head = nonempty && (starve_q == SW'(STARVE_MAX));
  assign in_ready   = !force_head;
  // Full check uses the registered count only, so a same-cycle pop never admits a push.
  assign lu_ready   = (count_q < CW'(DEPTH));
  assign pipe_req   = in_valid && in_regWrite && (in_rw != '0);
  assign pipe_grant = pipe_req && in_ready;
  assign head_grant = nonempty && !pipe_grant;
  assign push       = lu_valid && lu_ready && (lu_rd != '0);
  assign wd_pipe    = in_memToReg ? load_ext(in_Dout, in_EXout[L-1:0], in_size, in_isLOADS)
                                  : in_EXout;

  always_comb begin
    wptr_d   = push       ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = head_grant ? rptr_q + AW'(1) : rptr_q;
    count_d  = count_q + CW'(push) - CW'(head_grant);
    starve_d = starve_q;
    if (head_grant) begin
      starve_d = '0;
    end else if (nonempty && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
    wb_we_d = 1'b0;
    wb_wd_d = '0;
    wb_rw_d = '0;
    if (pipe_grant) begin
      wb_we_d = 1'b1;
      wb_wd_d = wd_pipe;
      wb_rw_d = in_rw;
    end else if (head_grant) begin
      wb_we_d = 1'b1;
      wb_wd_d = mem_data_q[rptr_q];
      wb_rw_d = mem_rd_q[rptr_q];
    end
  end

  // Stage boundary: arbitration result -> registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      starve_q <= '0;
      wb_we_q  <= 1'b0;
      wb_wd_q  <= '0;
      wb_rw_q  <= '0;
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      starve_q <= starve_d;
      wb_we_q  <= wb_we_d;
      wb_wd_q  <= wb_wd_d;
      wb_rw_q  <= wb_rw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wptr_q]   <= lu_rd;
      mem_data_q[wptr_q] <= lu_data;
    end
  end

  assign o_WB_regWrite = wb_we_q;
  assign o_WB_BACK     = {wb_we_q, wb_wd_q, wb_rw_q};
  assign o_lu_count    = count_q;

endmodule

// File: tb/tb_wb_arb_stage.sv
// Bench for wb_arb_stage: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are compared each cycle against a queue-based reference model.
module tb_wb_arb_stage;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int SM    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_regWrite, in_memToReg, in_isLOADS;
  logic [1:0]    in_size;
  logic [RW-1:0] in_rw, lu_rd;
  logic [63:0]   in_EXout, in_Dout, lu_data;
  logic          lu_valid;

  logic          in_ready32, lu_ready32, we32;
  logic [37:0]   back32;
  logic [2:0]    cnt32;
  logic          in_ready64, lu_ready64, we64;
  logic [69:0]   back64;
  logic [2:0]    cnt64;

  wb_arb_stage #(.XLEN(32), .RW(RW), .DEPTH(DEPTH), .STARVE_MAX(SM)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_regWrite(in_regWrite), .in_memToReg(in_memToReg), .in_isLOADS(in_isLOADS),
    .in_size(in_size), .in_rw(in_rw), .in_EXout(in_EXout[31:0]), .in_Dout(in_Dout[31:0]),
    .lu_valid(lu_valid), .lu_ready(lu_ready32), .lu_rd(lu_rd), .lu_data(lu_data[31:0]),
    .o_WB_regWrite(we32), .o_WB_BACK(back32), .o_lu_count(cnt32));

  wb_arb_stage #(.XLEN(64), .RW(RW), .DEPTH(DEPTH), .STARVE_MAX(SM)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_regWrite(in_regWrite), .in_memToReg(in_memToReg), .in_isLOADS(in_isLOADS),
    .in_size(in_size), .in_rw(in_rw), .in_EXout(in_EXout), .in_Dout(in_Dout),
    .lu_valid(lu_valid), .lu_ready(lu_ready64), .lu_rd(lu_rd), .lu_data(lu_data),
    .o_WB_regWrite(we64), .o_WB_BACK(back64), .o_lu_count(cnt64));

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [63:0]   data;
  } ent_t;

  ent_t          q[$];
  int            starve;
  logic          exp_we;
  logic [31:0]   exp_wd32;
  logic [63:0]   exp_wd64;
  logic [RW-1:0] exp_rw;
  logic          last_in_acc, last_lu_acc;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pick the naturally aligned field containing the addressed byte, then extend it.
  function automatic logic [63:0] ref_ext(input int xlen, input logic [63:0] d,
                                          input logic [63:0] addr, input logic [1:0] size,
                                          input logic sgn);
    int nbytes, off, w, base;
    logic [63:0] f, mask;
    nbytes = xlen / 8;
    off    = int'(addr % nbytes);
    w      = 1 << size;
    if (w > nbytes) w = nbytes;
    base = off - (off % w);
    f    = d >> (8 * base);
    mask = (w == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * w)) - 64'd1);
    f    = f & mask;
    if (sgn && f[8*w-1]) f = f | ~mask;
    if (xlen == 32) f = f & 64'hFFFF_FFFF;
    return f;
  endfunction

  function automatic logic [63:0] wd_ref(input int xlen);
    logic [63:0] m;
    m = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    if (!in_memToReg) return in_EXout & m;
    return ref_ext(xlen, in_Dout & m, in_EXout, in_size, in_isLOADS);
  endfunction

  task automatic model_reset();
    q.delete();
    starve      = 0;
    exp_we      = 1'b0;
    exp_wd32    = '0;
    exp_wd64    = '0;
    exp_rw      = '0;
    last_in_acc = 1'b1;
    last_lu_acc = 1'b0;
  endtask

  task automatic set_idle();
    in_valid = 0; in_regWrite = 0; in_memToReg = 0; in_isLOADS = 0; in_size = 2'b00;
    in_rw = '0; in_EXout = '0; in_Dout = '0; lu_valid = 0; lu_rd = '0; lu_data = '0;
  endtask

  // One clock: called at a falling edge with inputs already driven.
  task automatic tick();
    int          sz;
    logic        frc, pipe, acc;
    logic [63:0] t;
    ent_t        e;
    #1;
    sz  = q.size();
    frc = (sz != 0) && (starve == SM);
    chk("in_ready32", in_ready32, !frc);
    chk("in_ready64", in_ready64, !frc);
    chk("lu_ready32", lu_ready32, sz < DEPTH);
    chk("lu_ready64", lu_ready64, sz < DEPTH);
    chk("count32", cnt32, sz);
    chk("count64", cnt64, sz);
    pipe        = in_valid && in_regWrite && (in_rw != 0) && !frc;
    acc         = lu_valid && (sz < DEPTH);
    last_lu_acc = acc;
    last_in_acc = !in_valid || !frc;
    if (pipe) begin
      exp_we   = 1'b1;
      exp_rw   = in_rw;
      exp_wd64 = wd_ref(64);
      t        = wd_ref(32);
      exp_wd32 = t[31:0];
      if (sz != 0 && starve < SM) starve++;
    end else if (sz != 0) begin
      e        = q.pop_front();
      exp_we   = 1'b1;
      exp_rw   = e.rd;
      exp_wd64 = e.data;
      exp_wd32 = e.data[31:0];
      starve   = 0;
    end else begin
      exp_we   = 1'b0;
      exp_rw   = '0;
      exp_wd64 = '0;
      exp_wd32 = '0;
    end
    if (acc && lu_rd != 0) q.push_back('{rd: lu_rd, data: lu_data});
    @(negedge clk);
    chk("we32", we32, exp_we);
    chk("we64", we64, exp_we);
    chk("back32", back32, {exp_we, exp_wd32, exp_rw});
    chk("back64", back64, {exp_we, exp_wd64, exp_rw});
  endtask

  task automatic next_pipe_word();
    if (last_in_acc) in_EXout = {$urandom, $urandom};
  endtask

  initial begin
    int k;
    set_idle();
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we32", we32, 0);
    chk("rst_back64", back64, 0);
    chk("rst_cnt32", cnt32, 0);
    chk("rst_lu_ready64", lu_ready64, 1);
    chk("rst_in_ready32", in_ready32, 1);
    rst = 1'b1;

    // Byte load, signed then unsigned
    in_valid = 1; in_regWrite = 1; in_memToReg = 1; in_isLOADS = 1; in_size = 2'b00;
    in_rw = 5'd7; in_EXout = 64'h2; in_Dout = 64'h1280_3456;
    tick();
    chk("byte_s32", back32, {1'b1, 32'hFFFF_FF80, 5'd7});
    in_isLOADS = 0;
    tick();
    chk("byte_u32", back32, {1'b1, 32'h0000_0080, 5'd7});

    // Upper word of a dword at XLEN=64
    in_isLOADS = 1; in_size = 2'b10; in_EXout = 64'h4; in_Dout = 64'h8000_0001_0000_0002;
    tick();
    chk("word_s64", back64, {1'b1, 64'hFFFF_FFFF_8000_0001, 5'd7});
    chk("word_32", back32, {1'b1, 32'h0000_0002, 5'd7});

    // Single long-latency result with idle pipeline
    set_idle();
    lu_valid = 1; lu_rd = 5'd3; lu_data = 64'hAA;
    tick();
    set_idle();
    tick();
    chk("lu_lat32", back32, {1'b1, 32'hAA, 5'd3});
    chk("lu_cnt_after", cnt32, 0);

    // Starvation: continuous pipeline writes with one queued result
    in_valid = 1; in_regWrite = 1; in_memToReg = 0; in_rw = 5'd5; in_EXout = 64'h1234;
    lu_valid = 1; lu_rd = 5'd9; lu_data = 64'h55;
    tick();
    lu_valid = 0;
    for (int i = 0; i < 8; i++) begin
      next_pipe_word();
      tick();
    end

    // Fill the queue with five results under continuous pipeline writes
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      next_pipe_word();
      lu_valid = 1; lu_rd = RW'(10 + k); lu_data = 64'h100 + 64'(k);
      tick();
      if (last_lu_acc) k++;
    end
    chk("fill_accepted", k, 5);
    lu_valid = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      next_pipe_word();
      tick();
    end
    chk("fill_drained", cnt32, 0);

    // Reset with three queued entries and a pending write
    for (int i = 0; i < 3; i++) begin
      next_pipe_word();
      lu_valid = 1; lu_rd = RW'(20 + i); lu_data = 64'h200 + 64'(i);
      tick();
    end
    chk("pre_rst_cnt", cnt64, 3);
    set_idle();
    #2 rst = 1'b0;
    #1;
    chk("arst_we32", we32, 0);
    chk("arst_we64", we64, 0);
    chk("arst_cnt64", cnt64, 0);
    chk("arst_lu_ready32", lu_ready32, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) tick();

    // Randomized traffic, pipeline slot held while not accepted
    for (int i = 0; i < 400; i++) begin
      if (last_in_acc) begin
        in_valid    = ($urandom_range(3) != 0);
        in_regWrite = ($urandom_range(4) != 0);
        in_memToReg = $urandom_range(1);
        in_isLOADS  = $urandom_range(1);
        in_size     = 2'($urandom_range(3));
        in_rw       = RW'($urandom_range(31));
        in_EXout    = {$urandom, $urandom};
        in_Dout     = {$urandom, $urandom};
      end
      lu_valid = ($urandom_range(2) == 0);
      lu_rd    = RW'($urandom_range(31));
      lu_data  = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
